vliw_lsu: RTL and testbench

- Load/store unit between the two-slot VLIW execute stage and the single-port 8-bit data memory.
- Captures one bundle's memory ops (up to one per slot) and serialises them onto the single memory port: slot 0 first, then slot 1.
- Returns load results, tagged with destination register, to writeback.
- Stalls the issue stage while busy.

---
 rtl/vliw_lsu_if.sv | 63 ++++++
 rtl/vliw_lsu.sv | 187 ++++++++++++++++++
 tb/tb_vliw_lsu.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vliw_lsu_if.sv
// -----------------------------------------------------------------------------
// vliw_lsu_if
// Bundle, result and data-memory signals of the VLIW load/store unit.
//   slave  modport : the LSU side (takes bundles and read data, drives the
//                    memory port, Ready, Done and load results)
//   master modport : the execute stage / memory / writeback side
// Signals:
//   BundleValid, Ready                       bundle handshake
//   S{0,1}Valid/Write/Address/WriteData/Dest per-slot memory op fields
//   MemAddress, MemWriteData, MemWriteEnable single data-memory port
//   MemReadData                              combinational memory read data
//   Done, R{0,1}Valid/Dest/Data              bundle completion and load results
// Parameters must match those given to vliw_lsu.
// -----------------------------------------------------------------------------
interface vliw_lsu_if #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 3
) ();
    logic                      BundleValid;
    logic                      Ready;
    logic                      S0Valid;
    logic                      S0Write;
    logic [ADDR_WIDTH-1:0]     S0Address;
    logic [DATA_WIDTH-1:0]     S0WriteData;
    logic [REG_ADDR_WIDTH-1:0] S0Dest;
    logic                      S1Valid;
    logic                      S1Write;
    logic [ADDR_WIDTH-1:0]     S1Address;
    logic [DATA_WIDTH-1:0]     S1WriteData;
    logic [REG_ADDR_WIDTH-1:0] S1Dest;
    logic [ADDR_WIDTH-1:0]     MemAddress;
    logic [DATA_WIDTH-1:0]     MemWriteData;
    logic                      MemWriteEnable;
    logic [DATA_WIDTH-1:0]     MemReadData;
    logic                      Done;
    logic                      R0Valid;
    logic                      R1Valid;
    logic [REG_ADDR_WIDTH-1:0] R0Dest;
    logic [REG_ADDR_WIDTH-1:0] R1Dest;
    logic [DATA_WIDTH-1:0]     R0Data;
    logic [DATA_WIDTH-1:0]     R1Data;

    modport slave (
        input  BundleValid,
        input  S0Valid, S0Write, S0Address, S0WriteData, S0Dest,
        input  S1Valid, S1Write, S1Address, S1WriteData, S1Dest,
        input  MemReadData,
        output Ready,
        output MemAddress, MemWriteData, MemWriteEnable,
        output Done, R0Valid, R1Valid, R0Dest, R1Dest, R0Data, R1Data
    );

    modport master (
        output BundleValid,
        output S0Valid, S0Write, S0Address, S0WriteData, S0Dest,
        output S1Valid, S1Write, S1Address, S1WriteData, S1Dest,
        output MemReadData,
        input  Ready,
        input  MemAddress, MemWriteData, MemWriteEnable,
        input  Done, R0Valid, R1Valid, R0Dest, R1Dest, R0Data, R1Data
    );
endinterface

// File: rtl/vliw_lsu.sv
// -----------------------------------------------------------------------------
// vliw_lsu
// Load/store unit between the two-slot VLIW execute stage and a single-port
// data memory. A bundle (up to one memory op per slot) is captured when
// Ready && BundleValid, then its ops are played onto the memory port one per
// cycle, slot 0 first. Load data is registered at the end of its op cycle and
// presented, tagged with its destination register, alongside the one-cycle
// Done pulse that follows the last op.
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset (synchronous release expected)
//   bus    vliw_lsu_if.slave: bundle handshake, slot fields, memory port,
//          Done and load results
// Build option:
//   LSU_STORE_MERGE_EN  when defined, a bundle holding two stores to the same
//                       address skips the slot 0 store and performs only the
//                       slot 1 store (same final memory contents, one cycle
//                       shorter).
// -----------------------------------------------------------------------------
module vliw_lsu #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic         CLK,
    input  logic         RST_N,
    vliw_lsu_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, OP0, OP1} state_t;

    state_t state_reg, state_next;
    logic   done_reg, done_next;

    // Bundle fields regrouped per slot so both slots share one generate body.
    logic                      in_valid [2];
    logic                      in_write [2];
    logic [ADDR_WIDTH-1:0]     in_addr  [2];
    logic [DATA_WIDTH-1:0]     in_wdata [2];
    logic [REG_ADDR_WIDTH-1:0] in_dest  [2];

    // Capture registers for the accepted bundle.
    logic                      valid_reg [2];
    logic                      write_reg [2];
    logic [ADDR_WIDTH-1:0]     addr_reg  [2];
    logic [DATA_WIDTH-1:0]     wdata_reg [2];
    logic [REG_ADDR_WIDTH-1:0] dest_reg  [2];

    // Load result registers.
    logic                      rvalid_reg [2];
    logic [DATA_WIDTH-1:0]     rdata_reg  [2];
    logic [REG_ADDR_WIDTH-1:0] rdest_reg  [2];

    logic accept;
    logic merge_hit;
    logic op_active;
    logic op_slot;

    assign in_valid[0] = bus.S0Valid;
    assign in_write[0] = bus.S0Write;
    assign in_addr[0]  = bus.S0Address;
    assign in_wdata[0] = bus.S0WriteData;
    assign in_dest[0]  = bus.S0Dest;
    assign in_valid[1] = bus.S1Valid;
    assign in_write[1] = bus.S1Write;
    assign in_addr[1]  = bus.S1Address;
    assign in_wdata[1] = bus.S1WriteData;
    assign in_dest[1]  = bus.S1Dest;

    assign accept = (state_reg == IDLE) && bus.BundleValid;

`ifdef LSU_STORE_MERGE_EN
    // Two stores to one address: only the later (slot 1) store is visible,
    // so the slot 0 store can be dropped without changing memory contents.
    assign merge_hit = bus.S0Valid && bus.S0Write && bus.S1Valid && bus.S1Write
                       && (bus.S0Address == bus.S1Address);
`else
    assign merge_hit = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (in_valid[0] && !merge_hit) begin
                        state_next = OP0;
                    end else if (in_valid[1]) begin
                        state_next = OP1;
                    end else begin
                        // Empty bundle completes immediately.
                        done_next = 1'b1;
                    end
                end
            end
            OP0: begin
                if (valid_reg[1]) begin
                    state_next = OP1;
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            OP1: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------ memory port
    // Driven from state and capture registers only, never from bundle inputs.
    assign op_active = (state_reg == OP0) || (state_reg == OP1);
    assign op_slot   = (state_reg == OP1);

    assign bus.MemAddress     = op_active ? addr_reg[op_slot]  : '0;
    assign bus.MemWriteData   = op_active ? wdata_reg[op_slot] : '0;
    assign bus.MemWriteEnable = op_active && write_reg[op_slot];

    // ----------------------------------------------- per-slot capture/result
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            logic in_op;
            assign in_op = (gi == 0) ? (state_reg == OP0) : (state_reg == OP1);

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    valid_reg[gi] <= 1'b0;
                    write_reg[gi] <= 1'b0;
                    addr_reg[gi]  <= '0;
                    wdata_reg[gi] <= '0;
                    dest_reg[gi]  <= '0;
                end else if (accept) begin
                    valid_reg[gi] <= in_valid[gi];
                    write_reg[gi] <= in_write[gi];
                    addr_reg[gi]  <= in_addr[gi];
                    wdata_reg[gi] <= in_wdata[gi];
                    dest_reg[gi]  <= in_dest[gi];
                end
            end

            // rvalid is cleared on every accept so a slot without a load in
            // the new bundle reports nothing; data/dest keep their last value.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    rvalid_reg[gi] <= 1'b0;
                    rdata_reg[gi]  <= '0;
                    rdest_reg[gi]  <= '0;
                end else if (accept) begin
                    rvalid_reg[gi] <= 1'b0;
                end else if (in_op && !write_reg[gi]) begin
                    rvalid_reg[gi] <= 1'b1;
                    rdata_reg[gi]  <= bus.MemReadData;
                    rdest_reg[gi]  <= dest_reg[gi];
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------- outputs
    assign bus.Ready   = (state_reg == IDLE);
    assign bus.Done    = done_reg;
    // Slot 0 result may be registered a cycle before Done; gate so results
    // are only ever seen together with Done.
    assign bus.R0Valid = done_reg && rvalid_reg[0];
    assign bus.R1Valid = done_reg && rvalid_reg[1];
    assign bus.R0Data  = rdata_reg[0];
    assign bus.R1Data  = rdata_reg[1];
    assign bus.R0Dest  = rdest_reg[0];
    assign bus.R1Dest  = rdest_reg[1];

endmodule

// File: tb/tb_vliw_lsu.sv
// -----------------------------------------------------------------------------
// tb_vliw_lsu
// Bench for vliw_lsu: a behavioural data memory on the memory port, directed
// scenarios with fixed expected values, and random bundles checked against a
// bundle-level reference model (ordered list of memory ops plus a reference
// memory array).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vliw_lsu;

    logic clk;
    logic rst_n;

    vliw_lsu_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .REG_ADDR_WIDTH(3)) bus ();

    vliw_lsu #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .REG_ADDR_WIDTH(3)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Data memory: combinational read, write at rising edge; bench preload
    // goes through the same process.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       pl_en;
    logic [7:0] pl_addr, pl_data;

    assign bus.MemReadData = mem[bus.MemAddress];
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.MemWriteEnable) mem[bus.MemAddress] <= bus.MemWriteData;
    end

    // Stimulus for the next bundle.
    logic       s_valid [2];
    logic       s_write [2];
    logic [7:0] s_addr  [2];
    logic [7:0] s_wdata [2];
    logic [2:0] s_dest  [2];

    // Model expectations.
    int         exp_nops, exp_lat;
    logic [7:0] exp_addr [2];
    logic       exp_we   [2];
    logic [7:0] exp_wd   [2];
    logic       exp_rv   [2];
    logic [7:0] exp_rd   [2];
    logic [2:0] exp_rdest[2];

    // Observations.
    int         obs_nops, obs_lat, obs_wecnt;
    logic [7:0] obs_addr [4];
    logic       obs_we   [4];
    logic [7:0] obs_wd   [4];
    logic       obs_rv   [2];
    logic [7:0] obs_rd   [2];
    logic [2:0] obs_rdest[2];

    // Reference: the bundle's ops are the valid slots in slot order (slot 0
    // dropped when merging two same-address stores); each takes one cycle,
    // Done follows one cycle after the last; loads read the memory as left
    // by every earlier op.
    task automatic model_bundle();
        int  n;
        logic merge;
        n = 0;
        merge = 1'b0;
`ifdef LSU_STORE_MERGE_EN
        merge = s_valid[0] && s_write[0] && s_valid[1] && s_write[1]
                && (s_addr[0] == s_addr[1]);
`endif
        for (int i = 0; i < 2; i++) begin
            exp_rv[i] = 1'b0;
            if (s_valid[i] && !(i == 0 && merge)) begin
                exp_addr[n] = s_addr[i];
                exp_we[n]   = s_write[i];
                exp_wd[n]   = s_wdata[i];
                n++;
                if (s_write[i]) ref_mem[s_addr[i]] = s_wdata[i];
                else begin
                    exp_rv[i]    = 1'b1;
                    exp_rd[i]    = ref_mem[s_addr[i]];
                    exp_rdest[i] = s_dest[i];
                end
            end
        end
        exp_nops = n;
        exp_lat  = n + 1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic set_slot(input int i, input logic v, input logic w,
                            input logic [7:0] a, input logic [7:0] d, input logic [2:0] r);
        s_valid[i] = v; s_write[i] = w; s_addr[i] = a; s_wdata[i] = d; s_dest[i] = r;
    endtask

    // Presents s_* for one accept edge (called at a negedge with Ready=1),
    // scribbles the slot inputs afterwards, and records the memory port
    // while busy and the results in the Done cycle.
    task automatic issue_bundle();
        bus.S0Valid = s_valid[0]; bus.S0Write = s_write[0]; bus.S0Address = s_addr[0];
        bus.S0WriteData = s_wdata[0]; bus.S0Dest = s_dest[0];
        bus.S1Valid = s_valid[1]; bus.S1Write = s_write[1]; bus.S1Address = s_addr[1];
        bus.S1WriteData = s_wdata[1]; bus.S1Dest = s_dest[1];
        bus.BundleValid = 1'b1;
        $display("bundle s0(v%0d w%0d a%02h d%02h r%0d) s1(v%0d w%0d a%02h d%02h r%0d)",
                 s_valid[0], s_write[0], s_addr[0], s_wdata[0], s_dest[0],
                 s_valid[1], s_write[1], s_addr[1], s_wdata[1], s_dest[1]);
        @(posedge clk);
        #1;
        bus.BundleValid = 1'b0;
        {bus.S0Valid, bus.S0Write, bus.S0Address, bus.S0WriteData, bus.S0Dest} = 19'($urandom);
        {bus.S1Valid, bus.S1Write, bus.S1Address, bus.S1WriteData, bus.S1Dest} = 19'($urandom);
        obs_nops = 0; obs_lat = 0; obs_wecnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!bus.Ready) begin
                if (obs_nops < 4) begin
                    obs_addr[obs_nops] = bus.MemAddress;
                    obs_we[obs_nops]   = bus.MemWriteEnable;
                    obs_wd[obs_nops]   = bus.MemWriteData;
                end
                if (bus.MemWriteEnable) obs_wecnt++;
                obs_nops++;
            end
            if (bus.Done) begin
                obs_lat = k;
                obs_rv[0] = bus.R0Valid; obs_rd[0] = bus.R0Data; obs_rdest[0] = bus.R0Dest;
                obs_rv[1] = bus.R1Valid; obs_rd[1] = bus.R1Data; obs_rdest[1] = bus.R1Dest;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.Ready !== 1'b1 || bus.MemWriteEnable !== 1'b0 || bus.MemAddress !== 8'h00 ||
                bus.MemWriteData !== 8'h00 || bus.Done !== 1'b0 ||
                bus.R0Valid !== 1'b0 || bus.R1Valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle c%0d: got rdy=%b we=%b a=%h wd=%h done=%b rv=%b%b, want 1 0 00 00 0 00",
                         c, bus.Ready, bus.MemWriteEnable, bus.MemAddress, bus.MemWriteData,
                         bus.Done, bus.R0Valid, bus.R1Valid);
            end
        end
    endtask

    task automatic test_single_store();
        set_slot(0, 1, 1, 8'h10, 8'h5A, 3'd0);
        set_slot(1, 0, 0, 8'h00, 8'h00, 3'd0);
        model_bundle();
        issue_bundle();
        checks++;
        if (obs_lat !== 2 || obs_nops !== 1) begin
            errors++; $display("FAIL store_timing: got lat=%0d busy=%0d, want 2 1", obs_lat, obs_nops);
        end
        checks++;
        if (obs_addr[0] !== 8'h10 || obs_we[0] !== 1'b1 || obs_wd[0] !== 8'h5A) begin
            errors++; $display("FAIL store_port: got a=%h we=%b wd=%h, want 10 1 5a", obs_addr[0], obs_we[0], obs_wd[0]);
        end
        checks++;
        if (obs_rv[0] !== 1'b0 || obs_rv[1] !== 1'b0 || mem[8'h10] !== 8'h5A) begin
            errors++; $display("FAIL store_result: got rv=%b%b mem=%h, want 00 5a", obs_rv[0], obs_rv[1], mem[8'h10]);
        end
    endtask

    task automatic test_dual_load();
        preload(8'h20, 8'h33);
        preload(8'h21, 8'h44);
        @(negedge clk);
        set_slot(0, 1, 0, 8'h20, 8'hC1, 3'd2);
        set_slot(1, 1, 0, 8'h21, 8'hC2, 3'd5);
        model_bundle();
        issue_bundle();
        checks++;
        if (obs_lat !== 3 || obs_nops !== 2 || obs_wecnt !== 0) begin
            errors++; $display("FAIL load2_timing: got lat=%0d busy=%0d wes=%0d, want 3 2 0", obs_lat, obs_nops, obs_wecnt);
        end
        checks++;
        if (obs_addr[0] !== 8'h20 || obs_addr[1] !== 8'h21) begin
            errors++; $display("FAIL load2_addr: got %h %h, want 20 21", obs_addr[0], obs_addr[1]);
        end
        checks++;
        if (obs_rv[0] !== 1'b1 || obs_rdest[0] !== 3'd2 || obs_rd[0] !== 8'h33 ||
            obs_rv[1] !== 1'b1 || obs_rdest[1] !== 3'd5 || obs_rd[1] !== 8'h44) begin
            errors++;
            $display("FAIL load2_result: got R0=(%b,%0d,%h) R1=(%b,%0d,%h), want (1,2,33) (1,5,44)",
                     obs_rv[0], obs_rdest[0], obs_rd[0], obs_rv[1], obs_rdest[1], obs_rd[1]);
        end
    endtask

    task automatic test_ordering();
        set_slot(0, 1, 1, 8'h30, 8'h77, 3'd0);
        set_slot(1, 1, 0, 8'h30, 8'h00, 3'd1);
        model_bundle();
        issue_bundle();
        checks++;
        if (obs_rv[0] !== 1'b0 || obs_rv[1] !== 1'b1 || obs_rd[1] !== 8'h77 || obs_rdest[1] !== 3'd1) begin
            errors++; $display("FAIL raw_order: got rv=%b%b R1=(%0d,%h), want 01 (1,77)",
                               obs_rv[0], obs_rv[1], obs_rdest[1], obs_rd[1]);
        end
        set_slot(0, 1, 0, 8'h30, 8'h00, 3'd4);
        set_slot(1, 1, 1, 8'h30, 8'h88, 3'd0);
        model_bundle();
        issue_bundle();
        checks++;
        if (obs_rv[0] !== 1'b1 || obs_rd[0] !== 8'h77 || obs_rv[1] !== 1'b0 || mem[8'h30] !== 8'h88) begin
            errors++; $display("FAIL war_order: got rv=%b%b R0=%h mem=%h, want 10 77 88",
                               obs_rv[0], obs_rv[1], obs_rd[0], mem[8'h30]);
        end
    endtask

    task automatic test_dual_store();
        int want_lat, want_we;
`ifdef LSU_STORE_MERGE_EN
        want_lat = 2; want_we = 1;
`else
        want_lat = 3; want_we = 2;
`endif
        set_slot(0, 1, 1, 8'h40, 8'h11, 3'd0);
        set_slot(1, 1, 1, 8'h40, 8'h22, 3'd0);
        model_bundle();
        issue_bundle();
        checks++;
        if (obs_lat !== want_lat || obs_wecnt !== want_we || mem[8'h40] !== 8'h22) begin
            errors++; $display("FAIL dual_store: got lat=%0d wes=%0d mem=%h, want %0d %0d 22",
                               obs_lat, obs_wecnt, mem[8'h40], want_lat, want_we);
        end
    endtask

    task automatic test_empty_bundle();
        set_slot(0, 0, 1, 8'h50, 8'h99, 3'd3);
        set_slot(1, 0, 1, 8'h51, 8'h98, 3'd4);
        model_bundle();
        issue_bundle();
        checks++;
        if (obs_lat !== 1 || obs_nops !== 0 || obs_rv[0] !== 1'b0 || obs_rv[1] !== 1'b0) begin
            errors++; $display("FAIL empty_bundle: got lat=%0d busy=%0d rv=%b%b, want 1 0 00",
                               obs_lat, obs_nops, obs_rv[0], obs_rv[1]);
        end
    endtask

    // Random bundles over a small address window so conflicts are common;
    // gap 0 means the next bundle is accepted in the Done cycle.
    task automatic test_random(input int count);
        for (int t = 0; t < count; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                @(negedge clk);
                checks++;
                if (bus.Done !== 1'b0 || bus.R0Valid !== 1'b0 || bus.R1Valid !== 1'b0 || bus.Ready !== 1'b1) begin
                    errors++; $display("FAIL rand_after_done t%0d: got done=%b rv=%b%b rdy=%b, want 0 00 1",
                                       t, bus.Done, bus.R0Valid, bus.R1Valid, bus.Ready);
                end
                repeat (gap - 1) @(negedge clk);
            end
            for (int i = 0; i < 2; i++)
                set_slot(i, 1'($urandom), 1'($urandom), 8'($urandom_range(8'h60, 8'h63)),
                         8'($urandom), 3'($urandom));
            model_bundle();
            issue_bundle();
            checks++;
            if (obs_lat !== exp_lat || obs_nops !== exp_nops) begin
                errors++; $display("FAIL rand_timing t%0d: got lat=%0d busy=%0d, want %0d %0d",
                                   t, obs_lat, obs_nops, exp_lat, exp_nops);
            end
            for (int j = 0; j < exp_nops; j++) begin
                checks++;
                if (obs_addr[j] !== exp_addr[j] || obs_we[j] !== exp_we[j] || obs_wd[j] !== exp_wd[j]) begin
                    errors++; $display("FAIL rand_port t%0d op%0d: got a=%h we=%b wd=%h, want %h %b %h",
                                       t, j, obs_addr[j], obs_we[j], obs_wd[j], exp_addr[j], exp_we[j], exp_wd[j]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_rv[i] !== exp_rv[i] ||
                    (exp_rv[i] && (obs_rd[i] !== exp_rd[i] || obs_rdest[i] !== exp_rdest[i]))) begin
                    errors++; $display("FAIL rand_result t%0d R%0d: got (%b,%0d,%h), want (%b,%0d,%h)",
                                       t, i, obs_rv[i], obs_rdest[i], obs_rd[i], exp_rv[i], exp_rdest[i], exp_rd[i]);
                end
            end
            for (int a = 8'h60; a <= 8'h63; a++) begin
                checks++;
                if (mem[a] !== ref_mem[a]) begin
                    errors++; $display("FAIL rand_mem t%0d @%h: got %h, want %h", t, a, mem[a], ref_mem[a]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        set_slot(0, 1, 1, 8'h70, 8'hA1, 3'd0);
        set_slot(1, 0, 0, 8'h00, 8'h00, 3'd0);
        model_bundle();
        issue_bundle();
        // Still in the first bundle's Done cycle: the next accept happens here.
        set_slot(0, 1, 0, 8'h70, 8'h00, 3'd6);
        set_slot(1, 1, 1, 8'h71, 8'hB2, 3'd0);
        model_bundle();
        issue_bundle();
        checks++;
        if (obs_lat !== 3 || obs_rv[0] !== 1'b1 || obs_rd[0] !== 8'hA1 || obs_rdest[0] !== 3'd6 ||
            obs_rv[1] !== 1'b0 || mem[8'h71] !== 8'hB2) begin
            errors++; $display("FAIL back_to_back: got lat=%0d R0=(%b,%0d,%h) rv1=%b mem=%h, want 3 (1,6,a1) 0 b2",
                               obs_lat, obs_rv[0], obs_rdest[0], obs_rd[0], obs_rv[1], mem[8'h71]);
        end
    endtask

    task automatic test_reset_midop();
        bus.S0Valid = 1; bus.S0Write = 0; bus.S0Address = 8'h20; bus.S0WriteData = 8'h00; bus.S0Dest = 3'd2;
        bus.S1Valid = 1; bus.S1Write = 0; bus.S1Address = 8'h21; bus.S1WriteData = 8'h00; bus.S1Dest = 3'd5;
        bus.BundleValid = 1'b1;
        $display("bundle two loads 20/21, reset during OP0");
        @(posedge clk);
        #1 bus.BundleValid = 1'b0;
        checks++;
        if (bus.Ready !== 1'b0 || bus.MemAddress !== 8'h20) begin
            errors++; $display("FAIL midop_setup: got rdy=%b a=%h, want 0 20", bus.Ready, bus.MemAddress);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.Ready !== 1'b1 || bus.MemWriteEnable !== 1'b0 || bus.MemAddress !== 8'h00 ||
            bus.MemWriteData !== 8'h00 || bus.Done !== 1'b0) begin
            errors++; $display("FAIL midop_reset: got rdy=%b we=%b a=%h wd=%h done=%b, want 1 0 00 00 0",
                               bus.Ready, bus.MemWriteEnable, bus.MemAddress, bus.MemWriteData, bus.Done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.Ready !== 1'b1 || bus.Done !== 1'b0 || bus.MemWriteEnable !== 1'b0 ||
                bus.MemAddress !== 8'h00 || bus.R0Valid !== 1'b0 || bus.R1Valid !== 1'b0) begin
                errors++; $display("FAIL midop_after c%0d: got rdy=%b done=%b we=%b a=%h rv=%b%b, want 1 0 0 00 00",
                                   c, bus.Ready, bus.Done, bus.MemWriteEnable, bus.MemAddress,
                                   bus.R0Valid, bus.R1Valid);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        bus.BundleValid = 1'b0;
        bus.S0Valid = 0; bus.S0Write = 0; bus.S0Address = '0; bus.S0WriteData = '0; bus.S0Dest = '0;
        bus.S1Valid = 0; bus.S1Write = 0; bus.S1Address = '0; bus.S1WriteData = '0; bus.S1Dest = '0;
        for (int a = 0; a < 256; a++) preload(8'(a), 8'($urandom));
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single_store();
        test_dual_load();
        test_ordering();
        test_dual_store();
        test_empty_bundle();
        test_back_to_back();
        test_random(60);
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
